minimig_host_bus_arbiter: RTL
=============================

// Module: minimig_host_bus_arbiter
// PURPOSE
//  Shares the m68k bridge host port (cpu_halt/host_cs/adr/we/bs/wdat -> host_ack/rdat) among NREQ requesters
//  (OSD/SPI host, debug monitor, ...). Halts the CPU at a bus-idle point, runs one 16-bit access per grant,
//  round-robin between requesters, and releases the CPU when no request is left. Sits between requesters and bridge.
// PARAMETERS
//  NREQ        2    number of requesters (1..4)
//  SETTLE      2    clk7_en ticks after halt is seen taken before first host_cs
//  TIMEOUT     255  clk7_en ticks waiting for host_ack before abort (8-bit counter)
//  HOLD        4    clk7_en ticks halt is kept after last access (back-to-back window)
// PORTS
//  clk          in   1          28 MHz system clock
//  rst          in   1          synchronous reset, active high
//  clk7_en      in   1          7 MHz clock enable
//  cpu_as_n     in   1          CPU _as (1 = bus idle)
//  req          in   NREQ       per-requester request, held until its ack
//  req_we       in   NREQ       1 = write
//  req_adr      in   NREQ*23    word address [23:1], slice i = requester i
//  req_bs       in   NREQ*2     byte strobes {upper,lower}
//  req_wdat     in   NREQ*16    write data
//  ack          out  NREQ       one-clk pulse, access complete
//  err          out  NREQ       one-clk pulse with ack when access timed out
//  rdat         out  16         read data, valid in the ack cycle
//  cpu_halt     out  1          to bridge cpu_halt
//  host_cs      out  1          to bridge host_cs
//  host_adr/host_we/host_bs/host_wdat  out 23/1/2/16  to bridge, registered, stable while host_cs=1
//  host_rdat    in   16         from bridge
//  host_ack     in   1          from bridge (cleared asynchronously by bridge when host_cs falls)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; counters 0.
//  States: IDLE -> HALT_REQ -> SETTLE -> ACCESS -> GAP -> (ACCESS | HOLD) -> IDLE.
//  IDLE: any req -> cpu_halt<=1, HALT_REQ.
//  HALT_REQ: on clk7_en with cpu_as_n=1 sampled, go SETTLE (bridge halt latches on that same tick).
//  SETTLE: count SETTLE clk7_en ticks; then pick winner, latch its adr/we/bs/wdat, host_cs<=1, ACCESS.
//  Winner: round-robin, first req set starting at index rr; rr <= winner+1 (mod NREQ) on grant.
//  ACCESS: host_ack=1 -> capture host_rdat to rdat, ack[w]=1 for 1 clk, host_cs<=0, GAP.
//   Timeout: TIMEOUT clk7_en ticks without host_ack -> host_cs<=0, ack[w]=err[w]=1, rdat<=16'hFFFF, GAP.
//   Counter clears on every new grant.
//  GAP: one full clk7_en period with host_cs=0 (bridge _ta_n must clear). Then req pending (excluding just-acked
//   requester in the ack cycle) -> new grant directly into ACCESS, no halt/settle; else HOLD.
//  HOLD: cpu_halt stays 1 for HOLD ticks; new req -> grant into ACCESS; expiry -> cpu_halt<=0, IDLE.
//  Requester must deassert req in cycle after ack; a req still high then counts as a new request.
//  req dropped before grant: ignored, no ack. req dropped during ACCESS: access completes, ack still pulses.
//  Simultaneous reqs: exactly one grant per access; with all requesters active, grant order strictly rotates.
//  cpu_halt never drops while host_cs=1; host_cs never rises before SETTLE done.
//  rst mid-access: everything to reset values in one clk (host_cs=0, cpu_halt=0); no ack emitted.
//  Outputs are all registered; state advances only on clk7_en except ack/err pulse and host_cs fall (clk).
// STRUCTURE
//  Shared package/include minimig_host_arb_defs.vh: state encodings (3-bit), ST_IDLE..ST_HOLD, RDAT_TIMEOUT=16'hFFFF.
//  One sub-module: minimig_rr_arbiter (NREQ req + rr pointer -> one-hot grant + index, combinational).
//  Top holds FSM, tick counters, address/data capture mux.
// TESTING
//  1 req0 read 0x0DFF004, cpu_as_n=1: cpu_halt up, host_cs after HALT_REQ+2 ticks, host_ack w/ rdat 0x1234
//    -> ack[0] 1 clk, rdat=0x1234, halt drops after 4 idle ticks.
//  2 cpu_as_n=0 for 10 ticks then 1: host_cs stays 0 until as_n high is sampled + SETTLE; no early grant.
//  3 req0,req1 held asserted continuously: grants 0,1,0,1; halt never drops between; GAP >=1 tick host_cs=0.
//  4 bridge never acks: after 255 ticks ack[1]=err[1]=1, rdat=0xFFFF, host_cs=0, then release.
//  5 req1 write bs=2'b10 wdat=0xBEEF adr=0x000100: host_we=1, host_bs=10, host_wdat=0xBEEF stable for whole host_cs.
//  6 rst pulse during ACCESS: next clk host_cs=0, cpu_halt=0, no ack; fresh req afterwards completes normally.

Source files
------------

// File: rtl/minimig_host_bus_arbiter_pkg.sv
// Shared types and constants for the m68k bridge host-port arbiter.
// State encodings, timeout read value and index-width helper.
package minimig_host_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HALT_REQ = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_GAP      = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  localparam logic [15:0] RDAT_TIMEOUT = 16'hFFFF;
  localparam int ADR_W = 23;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minimig_host_bus_arbiter_rr.sv
// Round-robin pick: first set request at or after the rotating pointer.
// Purely combinational, one-hot grant plus binary index.
module minimig_rr_arbiter
  import minimig_host_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_vld;

  always_comb begin
    int k;
    w_gnt = '0;
    w_idx = '0;
    w_vld = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(i_ptr) + i) % NREQ;
      if (!w_vld && i_req[k]) begin
        w_vld    = 1'b1;
        w_gnt[k] = 1'b1;
        w_idx    = IW'(k);
      end
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_vld = w_vld;

endmodule

// File: rtl/minimig_host_bus_arbiter.sv
// Shares the bridge host port among NREQ requesters: halts the CPU,
// runs one 16-bit access per grant round-robin, releases when idle.
module minimig_host_bus_arbiter
  import minimig_host_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255,
  parameter int HOLD    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clk7_en,
  input  logic               i_cpu_as_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_req_we,
  input  logic [NREQ*23-1:0] i_req_adr,
  input  logic [NREQ*2-1:0]  i_req_bs,
  input  logic [NREQ*16-1:0] i_req_wdat,
  output logic [NREQ-1:0]    o_ack,
  output logic [NREQ-1:0]    o_err,
  output logic [15:0]        o_rdat,
  output logic               o_cpu_halt,
  output logic               o_host_cs,
  output logic [22:0]        o_host_adr,
  output logic               o_host_we,
  output logic [1:0]         o_host_bs,
  output logic [15:0]        o_host_wdat,
  input  logic [15:0]        i_host_rdat,
  input  logic               i_host_ack
);

  localparam int IW = idx_w(NREQ);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [IW-1:0]   r_rr;
  logic [NREQ-1:0] r_gnt;
  logic            r_halt;
  logic            r_cs;
  logic [22:0]     r_adr;
  logic            r_we;
  logic [1:0]      r_bs;
  logic [15:0]     r_wdat;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_err;
  logic [15:0]     r_rdat;

  state_t          w_state_nx;
  logic [7:0]      w_cnt_nx;
  logic [IW-1:0]   w_rr_nx;
  logic [NREQ-1:0] w_gnt_nx;
  logic            w_halt_nx;
  logic            w_cs_nx;
  logic [22:0]     w_adr_nx;
  logic            w_we_nx;
  logic [1:0]      w_bs_nx;
  logic [15:0]     w_wdat_nx;
  logic [NREQ-1:0] w_ack_nx;
  logic [NREQ-1:0] w_err_nx;
  logic [15:0]     w_rdat_nx;
  logic            w_grant;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_vld;

  minimig_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (r_rr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_vld (w_arb_vld)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rr_nx    = r_rr;
    w_gnt_nx   = r_gnt;
    w_halt_nx  = r_halt;
    w_cs_nx    = r_cs;
    w_adr_nx   = r_adr;
    w_we_nx    = r_we;
    w_bs_nx    = r_bs;
    w_wdat_nx  = r_wdat;
    w_ack_nx   = '0;
    w_err_nx   = '0;
    w_rdat_nx  = r_rdat;
    w_grant    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_clk7_en && |i_req) begin
          w_halt_nx  = 1'b1;
          w_state_nx = ST_HALT_REQ;
        end
      end
      ST_HALT_REQ: begin
        if (i_clk7_en && i_cpu_as_n) begin
          w_state_nx = ST_SETTLE;
          w_cnt_nx   = '0;
        end
      end
      ST_SETTLE: begin
        if (i_clk7_en) begin
          if (r_cnt == 8'(SETTLE - 1)) begin
            if (w_arb_vld) begin
              w_grant = 1'b1;
            end else begin
              w_state_nx = ST_HOLD;
              w_cnt_nx   = '0;
            end
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      ST_ACCESS: begin
        if (i_host_ack) begin
          w_ack_nx   = r_gnt;
          w_rdat_nx  = i_host_rdat;
          w_cs_nx    = 1'b0;
          w_state_nx = ST_GAP;
          w_cnt_nx   = '0;
        end else if (i_clk7_en) begin
          if (r_cnt == 8'(TIMEOUT - 1)) begin
            w_ack_nx   = r_gnt;
            w_err_nx   = r_gnt;
            w_rdat_nx  = RDAT_TIMEOUT;
            w_cs_nx    = 1'b0;
            w_state_nx = ST_GAP;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      // first tick may be partial; deciding on the second one
      // guarantees a full clk7 period with host_cs low
      ST_GAP: begin
        if (i_clk7_en) begin
          if (r_cnt == 8'd0) begin
            w_cnt_nx = 8'd1;
          end else if (w_arb_vld) begin
            w_grant = 1'b1;
          end else begin
            w_state_nx = ST_HOLD;
            w_cnt_nx   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (i_clk7_en) begin
          if (w_arb_vld) begin
            w_grant = 1'b1;
          end else if (r_cnt == 8'(HOLD - 1)) begin
            w_halt_nx  = 1'b0;
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    if (w_grant) begin
      w_state_nx = ST_ACCESS;
      w_cnt_nx   = '0;
      w_cs_nx    = 1'b1;
      w_gnt_nx   = w_arb_gnt;
      w_adr_nx   = i_req_adr[int'(w_arb_idx)*ADR_W +: ADR_W];
      w_we_nx    = i_req_we[w_arb_idx];
      w_bs_nx    = i_req_bs[int'(w_arb_idx)*2 +: 2];
      w_wdat_nx  = i_req_wdat[int'(w_arb_idx)*16 +: 16];
      w_rr_nx    = (w_arb_idx == IW'(NREQ - 1)) ? '0
                                                 : w_arb_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_halt  <= 1'b0;
      r_cs    <= 1'b0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_bs    <= '0;
      r_wdat  <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_rr    <= w_rr_nx;
      r_gnt   <= w_gnt_nx;
      r_halt  <= w_halt_nx;
      r_cs    <= w_cs_nx;
      r_adr   <= w_adr_nx;
      r_we    <= w_we_nx;
      r_bs    <= w_bs_nx;
      r_wdat  <= w_wdat_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
      r_rdat  <= w_rdat_nx;
    end
  end

  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_rdat      = r_rdat;
  assign o_cpu_halt  = r_halt;
  assign o_host_cs   = r_cs;
  assign o_host_adr  = r_adr;
  assign o_host_we   = r_we;
  assign o_host_bs   = r_bs;
  assign o_host_wdat = r_wdat;

endmodule
